bcd_display_sequencer: RTL and testbench

- Sequences the shared binary-to-BCD conversion for the display path.
- On each `start_bcd` pulse from the mode controller, it selects one of four measured values (DAY, AVS, TIM, MAX) by `mode_flags` and latches it.
- It converts the value serially with shift-add-3 (double dabble), then publishes packed BCD digits with a one-cycle `done` pulse.
- It sits between the mode controller and the 7-segment/LCD digit driver.

---
 rtl/bcd_display_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_bcd_display_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : bcd_display_sequencer
// Description : Selects one of four measured values, saturates it, and converts
//               it serially to packed BCD for the digit driver.
//               Optional build macro: LEADING_ZERO_BLANK_EN (blank leading zeros).
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_display_sequencer #(
    parameter int IN_W   = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_bcd,
    input  logic [1:0]            mode_flags,
    input  logic [IN_W-1:0]       day_val,
    input  logic [IN_W-1:0]       avs_val,
    input  logic [IN_W-1:0]       tim_val,
    input  logic [IN_W-1:0]       max_val,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [1:0]            mode_out,
    output logic                  overflow,
    output logic                  busy,
    output logic                  done
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(IN_W + 1);

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

    localparam int              SAT_VAL = pow10(DIGITS) - 1;
    localparam logic [IN_W-1:0] SAT_IN  = IN_W'(SAT_VAL);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IN_W-1:0]    bin_q, bin_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         cap_mode_q, cap_mode_d;
    logic               cap_ovf_q, cap_ovf_d;
    logic               pending_q, pending_d;
    logic [BCD_W-1:0]   bcd_out_q, bcd_out_d;
    logic [1:0]         mode_out_q, mode_out_d;
    logic               ovf_out_q, ovf_out_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [IN_W-1:0]    w_sel_val;
    logic               w_sat;
    logic [BCD_W-1:0]   w_adj;
    logic [BCD_W-1:0]   w_publish;

    always_comb begin
        w_sel_val = day_val;
        case (mode_flags)
            2'b00:   w_sel_val = day_val;
            2'b01:   w_sel_val = avs_val;
            2'b10:   w_sel_val = tim_val;
            default: w_sel_val = max_val;
        endcase
        w_sat = (w_sel_val > SAT_IN);
    end

    // Add-3 correction applied to every digit before the shift.
    always_comb begin
        w_adj = scratch_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_adj[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = w_adj[4*i +: 4] + 4'd3;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    function automatic logic [BCD_W-1:0] blank_leading(input logic [BCD_W-1:0] raw);
        logic [BCD_W-1:0] r;
        logic             lead;
        r    = raw;
        lead = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (lead && (r[4*i +: 4] == 4'd0)) begin
                r[4*i +: 4] = 4'hF;
            end else begin
                lead = 1'b0;
            end
        end
        return r;
    endfunction

    always_comb w_publish = blank_leading(scratch_q);
`else
    always_comb w_publish = scratch_q;
`endif

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        cap_mode_d = cap_mode_q;
        cap_ovf_d  = cap_ovf_q;
        pending_d  = pending_q;
        bcd_out_d  = bcd_out_q;
        mode_out_d = mode_out_q;
        ovf_out_d  = ovf_out_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_bcd) begin
                    cap_mode_d = mode_flags;
                    cap_ovf_d  = w_sat;
                    bin_d      = w_sat ? SAT_IN : w_sel_val;
                    scratch_d  = '0;
                    cnt_d      = CNT_W'(IN_W);
                    state_d    = S_SHIFT;
                    busy_d     = 1'b1;
                end
            end

            S_SHIFT: begin
                busy_d    = 1'b1;
                scratch_d = {w_adj[BCD_W-2:0], bin_q[IN_W-1]};
                bin_d     = {bin_q[IN_W-2:0], 1'b0};
                cnt_d     = cnt_q - CNT_W'(1);
                if (start_bcd) begin
                    pending_d = 1'b1;
                end
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                bcd_out_d  = w_publish;
                mode_out_d = cap_mode_q;
                ovf_out_d  = cap_ovf_q;
                done_d     = 1'b1;
                // A start arriving on this very edge is treated as already pending.
                if (pending_q || start_bcd) begin
                    pending_d  = 1'b0;
                    cap_mode_d = mode_flags;
                    cap_ovf_d  = w_sat;
                    bin_d      = w_sat ? SAT_IN : w_sel_val;
                    scratch_d  = '0;
                    cnt_d      = CNT_W'(IN_W);
                    state_d    = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            bin_q      <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            cap_mode_q <= 2'b00;
            cap_ovf_q  <= 1'b0;
            pending_q  <= 1'b0;
            bcd_out_q  <= '0;
            mode_out_q <= 2'b00;
            ovf_out_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            cap_mode_q <= cap_mode_d;
            cap_ovf_q  <= cap_ovf_d;
            pending_q  <= pending_d;
            bcd_out_q  <= bcd_out_d;
            mode_out_q <= mode_out_d;
            ovf_out_q  <= ovf_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bcd_out  = bcd_out_q;
    assign mode_out = mode_out_q;
    assign overflow = ovf_out_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_display_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_display_sequencer
// Description : Bench for bcd_display_sequencer: directed scenarios plus random
//               traffic checked every cycle against a countdown reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_display_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_bcd = 1'b0;
    logic [1:0]  mode_flags = 2'b00;
    logic [13:0] day_val = '0;
    logic [13:0] avs_val = '0;
    logic [13:0] tim_val = '0;
    logic [13:0] max_val = '0;
    logic [15:0] bcd_out;
    logic [1:0]  mode_out;
    logic        overflow;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_en = 1'b0;

    bcd_display_sequencer #(.IN_W(14), .DIGITS(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_bcd  (start_bcd),
        .mode_flags (mode_flags),
        .day_val    (day_val),
        .avs_val    (avs_val),
        .tim_val    (tim_val),
        .max_val    (max_val),
        .bcd_out    (bcd_out),
        .mode_out   (mode_out),
        .overflow   (overflow),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Decimal rendering of a value, saturated to 9999, optionally leading-blanked.
    function automatic logic [15:0] to_bcd(input int v);
        int          s;
        logic [15:0] r;
        s = (v > 9999) ? 9999 : v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(s % 10);
            s = s / 10;
        end
`ifdef LEADING_ZERO_BLANK_EN
        for (int i = 3; i >= 1; i--) begin
            if (r[4*i +: 4] != 4'd0) break;
            r[4*i +: 4] = 4'hF;
        end
`endif
        return r;
    endfunction

    function automatic int pick(input logic [1:0] m, input logic [13:0] d,
                                input logic [13:0] a, input logic [13:0] t,
                                input logic [13:0] x);
        case (m)
            2'b00:   return int'(d);
            2'b01:   return int'(a);
            2'b10:   return int'(t);
            default: return int'(x);
        endcase
    endfunction

    function automatic logic [15:0] lit(input logic [15:0] raw, input logic [15:0] blanked);
`ifdef LEADING_ZERO_BLANK_EN
        return blanked;
`else
        return raw;
`endif
    endfunction

    // Reference model: a conversion publishes 15 edges after its load edge.
    logic        m_active = 1'b0;
    int          m_t = 0;
    logic        m_pending = 1'b0;
    int          m_val = 0;
    logic [1:0]  m_mode = 2'b00;
    logic [15:0] e_bcd = '0;
    logic [1:0]  e_mode = 2'b00;
    logic        e_ovf = 1'b0;
    logic        e_busy = 1'b0;
    logic        e_done = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_active  <= 1'b0;
            m_t       <= 0;
            m_pending <= 1'b0;
            e_bcd     <= '0;
            e_mode    <= 2'b00;
            e_ovf     <= 1'b0;
            e_busy    <= 1'b0;
            e_done    <= 1'b0;
        end else begin
            e_done <= 1'b0;
            if (!m_active) begin
                e_busy <= start_bcd;
                if (start_bcd) begin
                    m_active <= 1'b1;
                    m_t      <= 15;
                    m_val    <= pick(mode_flags, day_val, avs_val, tim_val, max_val);
                    m_mode   <= mode_flags;
                end
            end else if (m_t > 1) begin
                m_t    <= m_t - 1;
                e_busy <= 1'b1;
                if (start_bcd) m_pending <= 1'b1;
            end else begin
                e_bcd  <= to_bcd(m_val);
                e_mode <= m_mode;
                e_ovf  <= (m_val > 9999);
                e_done <= 1'b1;
                e_busy <= 1'b0;
                if (m_pending || start_bcd) begin
                    m_pending <= 1'b0;
                    m_t       <= 15;
                    m_val     <= pick(mode_flags, day_val, avs_val, tim_val, max_val);
                    m_mode    <= mode_flags;
                end else begin
                    m_active <= 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("done",     32'(done),     32'(e_done));
            chk("busy",     32'(busy),     32'(e_busy));
            chk("bcd_out",  32'(bcd_out),  32'(e_bcd));
            chk("mode_out", 32'(mode_out), 32'(e_mode));
            chk("overflow", 32'(overflow), 32'(e_ovf));
        end
    end

    task automatic pulse_start();
        @(negedge clk) start_bcd = 1'b1;
        @(negedge clk) start_bcd = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_done: timeout after %0d cycles", n);
        end
    endtask

    task automatic convert(input string name, input logic [1:0] m, input int v,
                           input logic [15:0] exp_bcd, input logic exp_ovf);
        int n;
        mode_flags = m;
        case (m)
            2'b00:   day_val = 14'(v);
            2'b01:   avs_val = 14'(v);
            2'b10:   tim_val = 14'(v);
            default: max_val = 14'(v);
        endcase
        pulse_start();
        chk({name, "_busy"}, 32'(busy), 32'd1);
        wait_done(n);
        chk({name, "_lat"},  32'(n),        32'd15);
        chk({name, "_bcd"},  32'(bcd_out),  32'(exp_bcd));
        chk({name, "_ovf"},  32'(overflow), 32'(exp_ovf));
        chk({name, "_mode"}, 32'(mode_out), 32'(m));
        @(negedge clk);
    endtask

    initial begin
        int n;
        int cnt;

        // Reset held with start asserted.
        start_bcd = 1'b1;
        reset     = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_bcd",  32'(bcd_out),  32'd0);
        chk("rst_mode", 32'(mode_out), 32'd0);
        chk("rst_busy", 32'(busy),     32'd0);
        chk("rst_done", 32'(done),     32'd0);
        reset     = 1'b0;
        start_bcd = 1'b0;
        @(negedge clk);
        chk("rst_nostart", 32'(busy), 32'd0);

        convert("day1234", 2'b00, 1234,  16'h1234, 1'b0);
        convert("tim_sat", 2'b10, 16383, 16'h9999, 1'b1);
        convert("tim9999", 2'b10, 9999,  16'h9999, 1'b0);
        convert("tim0",    2'b10, 0,     lit(16'h0000, 16'hFFF0), 1'b0);

        // Starts while busy collapse into one back-to-back conversion.
        mode_flags = 2'b01;
        avs_val    = 14'd250;
        pulse_start();
        repeat (4) @(negedge clk);
        mode_flags = 2'b11;
        max_val    = 14'd480;
        repeat (3) pulse_start();
        wait_done(n);
        chk("pend1_bcd",  32'(bcd_out),  32'(lit(16'h0250, 16'hF250)));
        chk("pend1_mode", 32'(mode_out), 32'd1);
        @(negedge clk);
        wait_done(n);
        chk("pend2_lat",  32'(n + 1),    32'd15);
        chk("pend2_bcd",  32'(bcd_out),  32'(lit(16'h0480, 16'hF480)));
        chk("pend2_mode", 32'(mode_out), 32'd3);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) cnt++;
        end
        chk("no_third_done", 32'(cnt), 32'd0);

        // Reset in the middle of a conversion.
        mode_flags = 2'b00;
        day_val    = 14'd321;
        pulse_start();
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 32'(busy),    32'd0);
        chk("abort_bcd",  32'(bcd_out), 32'd0);
        cnt = 0;
        repeat (25) begin
            @(negedge clk);
            if (done === 1'b1) cnt++;
        end
        chk("abort_nodone", 32'(cnt), 32'd0);

        convert("day42",   2'b00, 42,   lit(16'h0042, 16'hFF42), 1'b0);
        convert("day1000", 2'b00, 1000, 16'h1000, 1'b0);
        convert("day7",    2'b00, 7,    lit(16'h0007, 16'hFFF7), 1'b0);

        // Random traffic; the compare process checks every cycle.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            start_bcd  = ($urandom_range(0, 5) == 0);
            reset      = ($urandom_range(0, 299) == 0);
            mode_flags = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0:       day_val = 14'($urandom_range(0, 16383));
                1:       day_val = 14'($urandom_range(0, 9999));
                default: day_val = 14'($urandom_range(0, 99));
            endcase
            avs_val = 14'($urandom_range(0, 16383));
            tim_val = 14'($urandom_range(0, 999));
            max_val = 14'($urandom_range(9990, 10010));
        end
        @(negedge clk);
        start_bcd = 1'b0;
        reset     = 1'b0;
        repeat (40) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
